// File: rtl/ad_ip_jesd204_tpl_adc_sof_align_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ad_ip_jesd204_tpl_adc_sof_align_ctrl_pkg
// Shared definitions for the TPL ADC SOF alignment controller:
//   - align_state_e : alignment FSM state encoding (also the align_state port value)
//   - CNT_W / ERR_W : widths of the lock/miss counters and the error counter
//   - sof_period()  : number of beats between SOF marks for a given beat/frame size
// ----------------------------------------------------------------------------
package ad_ip_jesd204_tpl_adc_sof_align_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_LOCKED = 2'd3
    } align_state_e;

    // LOCK_CNT / UNLOCK_CNT are limited to 1..15, so 4 bits cover both counters.
    localparam int CNT_W = 4;
    localparam int ERR_W = 16;

    // A frame spanning several beats carries one SOF every opf/opb beats;
    // a frame that fits in a beat produces SOF marks on every beat.
    function automatic int sof_period(input int opb, input int opf);
        if (opf > opb) begin
            return opf / opb;
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_adc_sof_align_ctrl_sof_lsb_enc.sv
// ----------------------------------------------------------------------------
// ad_ip_jesd204_tpl_adc_sof_align_ctrl_sof_lsb_enc
// Combinational lowest-set-bit encoder for the per-octet SOF mark vector.
// Ports:
//   sof     in  WIDTH  SOF mark per octet position
//   sel     out SEL_W  index of the lowest set bit (0 when sof is all-zero)
//   nonzero out 1      at least one SOF bit is set
// ----------------------------------------------------------------------------
module ad_ip_jesd204_tpl_adc_sof_align_ctrl_sof_lsb_enc #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
) (
    input  logic [WIDTH-1:0] sof,
    output logic [SEL_W-1:0] sel,
    output logic             nonzero
);

    // Priority encode: scanning from MSB down, the lowest set bit writes last.
    always_comb begin
        sel = {SEL_W{1'b0}};
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (sof[i]) begin
                sel = SEL_W'(i);
            end else begin
                sel = sel;
            end
        end
        nonzero = |sof;
    end

endmodule

// File: rtl/ad_ip_jesd204_tpl_adc_sof_align_ctrl.sv
// ----------------------------------------------------------------------------
// ad_ip_jesd204_tpl_adc_sof_align_ctrl
// Frame-alignment controller for the TPL ADC deframer. Hunts for a SOF octet
// position in the link_sof marks, verifies it over LOCK_CNT SOF beats, then
// holds the octet-rotate select frozen while locked. UNLOCK_CNT consecutive
// mismatching beats drop the lock. Link clock domain only.
// Ports:
//   clk          in  1                 link clock
//   resetn       in  1                 asynchronous active-low reset
//   enable       in  1                 alignment enable; low forces IDLE
//   link_valid   in  1                 beat qualifier; low holds all state
//   link_sof     in  OCTETS_PER_BEAT   SOF mark per octet position
//   err_clr      in  1                 clears err_cnt (wins over an increment)
//   align_sel    out SEL_W             octet rotate select (lowest set SOF bit)
//   align_valid  out 1                 high while LOCKED
//   align_state  out 2                 0 IDLE, 1 HUNT, 2 VERIFY, 3 LOCKED
//   err_cnt      out 16                saturating SOF mismatch count while LOCKED
// ----------------------------------------------------------------------------
module ad_ip_jesd204_tpl_adc_sof_align_ctrl
    import ad_ip_jesd204_tpl_adc_sof_align_ctrl_pkg::*;
#(
    parameter int OCTETS_PER_BEAT  = 8,
    parameter int OCTETS_PER_FRAME = 2,
    parameter int LOCK_CNT         = 4,
    parameter int UNLOCK_CNT       = 4
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               enable,
    input  logic                               link_valid,
    input  logic [OCTETS_PER_BEAT-1:0]         link_sof,
    input  logic                               err_clr,
    output logic [$clog2(OCTETS_PER_BEAT)-1:0] align_sel,
    output logic                               align_valid,
    output logic [1:0]                         align_state,
    output logic [ERR_W-1:0]                   err_cnt
);

    localparam int SEL_W      = $clog2(OCTETS_PER_BEAT);
    localparam int SOF_PERIOD = sof_period(OCTETS_PER_BEAT, OCTETS_PER_FRAME);
    localparam int PH_W       = (SOF_PERIOD > 1) ? $clog2(SOF_PERIOD) : 1;

    localparam logic [PH_W-1:0]            PH_ZERO    = {PH_W{1'b0}};
    localparam logic [PH_W-1:0]            PH_ONE     = PH_W'(32'd1);
    localparam logic [PH_W-1:0]            PH_LAST    = PH_W'(SOF_PERIOD - 1);
    // Phase after a capture beat: 1 mod SOF_PERIOD.
    localparam logic [PH_W-1:0]            PH_CAPTURE = (SOF_PERIOD > 1) ? PH_ONE : PH_ZERO;
    localparam logic [CNT_W-1:0]           CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]           CNT_ONE    = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0]           LOCK_TGT   = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0]           UNLOCK_TGT = CNT_W'(UNLOCK_CNT);
    localparam logic [ERR_W-1:0]           ERR_ZERO   = {ERR_W{1'b0}};
    localparam logic [ERR_W-1:0]           ERR_MAX    = {ERR_W{1'b1}};
    localparam logic [OCTETS_PER_BEAT-1:0] SOF_ZERO   = {OCTETS_PER_BEAT{1'b0}};
    // With a single-beat verify window the first capture already locks.
    localparam align_state_e               CAP_STATE  = (LOCK_CNT == 1) ? ST_LOCKED : ST_VERIFY;

    align_state_e                 state_r, state_nxt_s;
    logic [OCTETS_PER_BEAT-1:0]   pat_r, pat_nxt_s;
    logic [SEL_W-1:0]             sel_r, sel_nxt_s;
    logic [CNT_W-1:0]             cnt_r, cnt_nxt_s, cnt_inc_s;
    logic [CNT_W-1:0]             miss_r, miss_nxt_s, miss_inc_s;
    logic [PH_W-1:0]              ph_r, ph_nxt_s, ph_adv_s;
    logic [ERR_W-1:0]             err_cnt_r, err_nxt_s;
    logic                         valid_r;
    logic                         err_inc_s;
    logic                         capture_s;
    logic                         match_s;
    logic [SEL_W-1:0]             enc_sel_s;
    logic                         enc_nonzero_s;

    ad_ip_jesd204_tpl_adc_sof_align_ctrl_sof_lsb_enc #(
        .WIDTH (OCTETS_PER_BEAT),
        .SEL_W (SEL_W)
    ) u_lsb_enc (
        .sof     (link_sof),
        .sel     (enc_sel_s),
        .nonzero (enc_nonzero_s)
    );

    assign cnt_inc_s  = cnt_r + CNT_ONE;
    assign miss_inc_s = miss_r + CNT_ONE;
    assign ph_adv_s   = (ph_r == PH_LAST) ? PH_ZERO : (ph_r + PH_ONE);
    // SOF beats must repeat the captured pattern; beats in between carry no SOF.
    assign match_s    = (ph_r == PH_ZERO) ? (link_sof == pat_r) : (link_sof == SOF_ZERO);

    // Alignment FSM next-state and counter updates.
    always_comb begin
        state_nxt_s = state_r;
        pat_nxt_s   = pat_r;
        sel_nxt_s   = sel_r;
        cnt_nxt_s   = cnt_r;
        miss_nxt_s  = miss_r;
        ph_nxt_s    = ph_r;
        err_inc_s   = 1'b0;
        capture_s   = 1'b0;

        if (!enable) begin
            // pat/sel/err are kept; only the progress counters restart.
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
            miss_nxt_s  = CNT_ZERO;
            ph_nxt_s    = PH_ZERO;
        end else if (state_r == ST_IDLE) begin
            state_nxt_s = ST_HUNT;
        end else if (link_valid) begin
            case (state_r)
                ST_HUNT: begin
                    capture_s = enc_nonzero_s;
                end
                ST_VERIFY: begin
                    if (match_s) begin
                        ph_nxt_s = ph_adv_s;
                        // Only SOF-carrying beats count towards the lock.
                        if (ph_r == PH_ZERO) begin
                            cnt_nxt_s = cnt_inc_s;
                            if (cnt_inc_s == LOCK_TGT) begin
                                state_nxt_s = ST_LOCKED;
                                miss_nxt_s  = CNT_ZERO;
                            end else begin
                                state_nxt_s = ST_VERIFY;
                            end
                        end else begin
                            cnt_nxt_s = cnt_r;
                        end
                    end else if (enc_nonzero_s) begin
                        capture_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_HUNT;
                        cnt_nxt_s   = CNT_ZERO;
                        ph_nxt_s    = PH_ZERO;
                    end
                end
                ST_LOCKED: begin
                    ph_nxt_s = ph_adv_s;
                    if (match_s) begin
                        miss_nxt_s = CNT_ZERO;
                    end else begin
                        err_inc_s = 1'b1;
                        if (miss_inc_s == UNLOCK_TGT) begin
                            state_nxt_s = ST_HUNT;
                            miss_nxt_s  = CNT_ZERO;
                            cnt_nxt_s   = CNT_ZERO;
                            ph_nxt_s    = PH_ZERO;
                        end else begin
                            miss_nxt_s = miss_inc_s;
                        end
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end

        // Capture is the only place the rotate select may change.
        if (capture_s) begin
            pat_nxt_s   = link_sof;
            sel_nxt_s   = enc_sel_s;
            ph_nxt_s    = PH_CAPTURE;
            cnt_nxt_s   = CNT_ONE;
            miss_nxt_s  = CNT_ZERO;
            state_nxt_s = CAP_STATE;
        end else begin
            pat_nxt_s = pat_nxt_s;
        end
    end

    // Saturating mismatch counter; a clear wins over a coincident increment.
    always_comb begin
        if (err_clr) begin
            err_nxt_s = ERR_ZERO;
        end else if (err_inc_s && (err_cnt_r != ERR_MAX)) begin
            err_nxt_s = err_cnt_r + {{(ERR_W-1){1'b0}}, 1'b1};
        end else begin
            err_nxt_s = err_cnt_r;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            pat_r     <= SOF_ZERO;
            sel_r     <= {SEL_W{1'b0}};
            cnt_r     <= CNT_ZERO;
            miss_r    <= CNT_ZERO;
            ph_r      <= PH_ZERO;
            err_cnt_r <= ERR_ZERO;
            valid_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            pat_r     <= pat_nxt_s;
            sel_r     <= sel_nxt_s;
            cnt_r     <= cnt_nxt_s;
            miss_r    <= miss_nxt_s;
            ph_r      <= ph_nxt_s;
            err_cnt_r <= err_nxt_s;
            valid_r   <= (state_nxt_s == ST_LOCKED);
        end
    end

    assign align_sel   = sel_r;
    assign align_valid = valid_r;
    assign align_state = state_r;
    assign err_cnt     = err_cnt_r;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_sof_align_ctrl.sv
// ----------------------------------------------------------------------------
// Testbench for ad_ip_jesd204_tpl_adc_sof_align_ctrl.
// dut8: OPB=8, F=2 (SOF every beat), tracked every cycle by a reference model.
// dut4: OPB=4, F=8, UNLOCK_CNT=15 (SOF every other beat), hand-checked.
// ----------------------------------------------------------------------------
module tb_ad_ip_jesd204_tpl_adc_sof_align_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        en8, lv8, clr8;
    logic [7:0]  sof8;
    logic [2:0]  sel8;
    logic        av8;
    logic [1:0]  st8;
    logic [15:0] err8;

    logic        en4, lv4, clr4;
    logic [3:0]  sof4;
    logic [1:0]  sel4;
    logic        av4;
    logic [1:0]  st4;
    logic [15:0] err4;

    int n_chk  = 0;
    int n_fail = 0;

    ad_ip_jesd204_tpl_adc_sof_align_ctrl #(
        .OCTETS_PER_BEAT(8), .OCTETS_PER_FRAME(2), .LOCK_CNT(4), .UNLOCK_CNT(4)
    ) dut8 (
        .clk(clk), .resetn(resetn), .enable(en8), .link_valid(lv8), .link_sof(sof8),
        .err_clr(clr8), .align_sel(sel8), .align_valid(av8), .align_state(st8), .err_cnt(err8)
    );

    ad_ip_jesd204_tpl_adc_sof_align_ctrl #(
        .OCTETS_PER_BEAT(4), .OCTETS_PER_FRAME(8), .LOCK_CNT(4), .UNLOCK_CNT(15)
    ) dut4 (
        .clk(clk), .resetn(resetn), .enable(en4), .link_valid(lv4), .link_sof(sof4),
        .err_clr(clr4), .align_sel(sel4), .align_valid(av4), .align_state(st4), .err_cnt(err4)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model for dut8 (period 1, lock 4, unlock 4)
    localparam int M_PERIOD = 1;
    localparam int M_LOCK   = 4;
    localparam int M_UNLOCK = 4;
    int         m_st, m_cnt, m_miss, m_ph, m_sel, m_err;
    logic [7:0] m_pat;

    function automatic int lowest_bit(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic m_reset();
        m_st = 0; m_cnt = 0; m_miss = 0; m_ph = 0; m_sel = 0; m_err = 0; m_pat = 8'h00;
    endtask

    task automatic m_step(input bit en, input bit lv, input logic [7:0] sof, input bit clr);
        bit inc;
        bit ok;
        bit cap;
        inc = 1'b0;
        cap = 1'b0;
        ok  = (m_ph == 0) ? (sof == m_pat) : (sof == 8'h00);
        if (!en) begin
            m_st = 0; m_cnt = 0; m_miss = 0; m_ph = 0;
        end else if (m_st == 0) begin
            m_st = 1;
        end else if (lv) begin
            if (m_st == 1) begin
                cap = (sof != 8'h00);
            end else if (m_st == 2) begin
                if (ok) begin
                    if (m_ph == 0) m_cnt++;
                    m_ph = (m_ph + 1) % M_PERIOD;
                    if (m_cnt >= M_LOCK) begin m_st = 3; m_miss = 0; end
                end else if (sof != 8'h00) cap = 1'b1;
                else begin m_st = 1; m_cnt = 0; m_ph = 0; end
            end else begin
                m_ph = (m_ph + 1) % M_PERIOD;
                if (ok) m_miss = 0;
                else begin
                    m_miss++; inc = 1'b1;
                    if (m_miss >= M_UNLOCK) begin m_st = 1; m_miss = 0; m_cnt = 0; m_ph = 0; end
                end
            end
            if (cap) begin
                m_pat = sof; m_sel = lowest_bit(sof); m_ph = 1 % M_PERIOD; m_cnt = 1; m_miss = 0;
                m_st = (M_LOCK == 1) ? 3 : 2;
            end
        end
        if (clr) m_err = 0;
        else if (inc && m_err < 65535) m_err++;
    endtask

    // One clock: drive dut8 (dut4 inputs are set by the caller), step model, compare.
    task automatic cyc(input bit en, input bit lv, input logic [7:0] sof, input bit clr);
        en8 = en; lv8 = lv; sof8 = sof; clr8 = clr;
        @(posedge clk);
        m_step(en, lv, sof, clr);
        #1;
        chk("model_state", {14'd0, st8}, m_st[15:0]);
        chk("model_valid", {15'd0, av8}, {15'd0, (m_st == 3)});
        chk("model_sel",   {13'd0, sel8}, m_sel[15:0]);
        chk("model_err",   err8, m_err[15:0]);
    endtask

    task automatic idle8();
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    typedef struct {
        bit          en;
        bit          lv;
        logic [7:0]  sof;
        bit          clr;
        logic [1:0]  st;
        bit          av;
        logic [2:0]  sel;
        logic [15:0] err;
    } vec_t;

    vec_t vt[27];

    initial begin
        logic [7:0] cands[4];
        logic [7:0] cand;
        int         exp_e;
        int         ph4;
        int         k;

        // en lv sof clr | state valid sel err
        vt[0]  = '{1, 0, 8'h00, 0, 2'd1, 0, 3'd0, 16'd0};
        vt[1]  = '{1, 1, 8'h55, 0, 2'd2, 0, 3'd0, 16'd0};
        vt[2]  = '{1, 1, 8'h55, 0, 2'd2, 0, 3'd0, 16'd0};
        vt[3]  = '{1, 1, 8'h55, 0, 2'd2, 0, 3'd0, 16'd0};
        vt[4]  = '{1, 1, 8'h55, 0, 2'd3, 1, 3'd0, 16'd0};
        vt[5]  = '{1, 1, 8'hAA, 0, 2'd3, 1, 3'd0, 16'd1};
        vt[6]  = '{1, 1, 8'hAA, 0, 2'd3, 1, 3'd0, 16'd2};
        vt[7]  = '{1, 1, 8'hAA, 0, 2'd3, 1, 3'd0, 16'd3};
        vt[8]  = '{1, 1, 8'h55, 0, 2'd3, 1, 3'd0, 16'd3};
        vt[9]  = '{1, 1, 8'hAA, 0, 2'd3, 1, 3'd0, 16'd4};
        vt[10] = '{1, 1, 8'hAA, 0, 2'd3, 1, 3'd0, 16'd5};
        vt[11] = '{1, 1, 8'hAA, 0, 2'd3, 1, 3'd0, 16'd6};
        vt[12] = '{1, 1, 8'hAA, 0, 2'd1, 0, 3'd0, 16'd7};
        vt[13] = '{1, 1, 8'h10, 0, 2'd2, 0, 3'd4, 16'd7};
        vt[14] = '{1, 0, 8'h10, 0, 2'd2, 0, 3'd4, 16'd7};
        vt[15] = '{1, 1, 8'h10, 0, 2'd2, 0, 3'd4, 16'd7};
        vt[16] = '{1, 0, 8'h00, 0, 2'd2, 0, 3'd4, 16'd7};
        vt[17] = '{1, 1, 8'h10, 0, 2'd2, 0, 3'd4, 16'd7};
        vt[18] = '{1, 0, 8'hFF, 0, 2'd2, 0, 3'd4, 16'd7};
        vt[19] = '{1, 1, 8'h10, 0, 2'd3, 1, 3'd4, 16'd7};
        vt[20] = '{0, 1, 8'h10, 0, 2'd0, 0, 3'd4, 16'd7};
        vt[21] = '{0, 0, 8'h00, 1, 2'd0, 0, 3'd4, 16'd0};
        vt[22] = '{1, 0, 8'h00, 0, 2'd1, 0, 3'd4, 16'd0};
        vt[23] = '{1, 1, 8'h22, 0, 2'd2, 0, 3'd1, 16'd0};
        vt[24] = '{1, 1, 8'h22, 0, 2'd2, 0, 3'd1, 16'd0};
        vt[25] = '{1, 1, 8'h22, 0, 2'd2, 0, 3'd1, 16'd0};
        vt[26] = '{1, 1, 8'h22, 0, 2'd3, 1, 3'd1, 16'd0};

        cands[0] = 8'h55; cands[1] = 8'h22; cands[2] = 8'h10; cands[3] = 8'h80;

        resetn = 1'b0;
        en8 = 1'b0; lv8 = 1'b0; sof8 = 8'h00; clr8 = 1'b0;
        en4 = 1'b0; lv4 = 1'b0; sof4 = 4'h0; clr4 = 1'b0;
        m_reset();
        #12;
        chk("rst_state", {14'd0, st8}, 16'd0);
        chk("rst_valid", {15'd0, av8}, 16'd0);
        chk("rst_sel",   {13'd0, sel8}, 16'd0);
        chk("rst_err",   err8, 16'd0);
        chk("rst4_state", {14'd0, st4}, 16'd0);
        #10 resetn = 1'b1;

        // Lock, mismatch counting, unlock, recapture, idle beats, enable drop, relock
        for (int i = 0; i < 27; i++) begin
            cyc(vt[i].en, vt[i].lv, vt[i].sof, vt[i].clr);
            chk($sformatf("tbl%0d_state", i), {14'd0, st8}, {14'd0, vt[i].st});
            chk($sformatf("tbl%0d_valid", i), {15'd0, av8}, {15'd0, vt[i].av});
            chk($sformatf("tbl%0d_sel", i),   {13'd0, sel8}, {13'd0, vt[i].sel});
            chk($sformatf("tbl%0d_err", i),   err8, vt[i].err);
        end

        // Multi-beat frames: SOF 4'h4 on alternate beats
        en4 = 1'b1; lv4 = 1'b0; sof4 = 4'h0;
        idle8();
        chk("t3_hunt", {14'd0, st4}, 16'd1);
        for (int b = 0; b < 7; b++) begin
            lv4 = 1'b1;
            sof4 = (b % 2 == 0) ? 4'h4 : 4'h0;
            idle8();
            if (b == 5) chk("t3_verify_b6", {14'd0, st4}, 16'd2);
        end
        chk("t3_locked", {14'd0, st4}, 16'd3);
        chk("t3_valid",  {15'd0, av4}, 16'd1);
        chk("t3_sel",    {14'd0, sel4}, 16'd2);
        chk("t3_err0",   err4, 16'd0);
        sof4 = 4'h4;                   // odd beat: must carry no SOF
        idle8();
        chk("t3_odd_err", err4, 16'd1);
        chk("t3_odd_lock", {14'd0, st4}, 16'd3);
        sof4 = 4'h4;                   // even beat: match
        idle8();
        ph4 = 1;
        exp_e = 1;

        // Drive err_cnt to saturation while keeping the lock alive
        while (exp_e < 65535) begin
            k = (65535 - exp_e < 14) ? (65535 - exp_e) : 14;
            sof4 = 4'h1;
            repeat (k) idle8();
            exp_e += k;
            ph4 = (ph4 + k) % 2;
            sof4 = (ph4 == 0) ? 4'h4 : 4'h0;
            idle8();
            ph4 = (ph4 + 1) % 2;
        end
        chk("t6_sat", err4, 16'hFFFF);
        chk("t6_sat_lock", {14'd0, st4}, 16'd3);
        sof4 = 4'h1;
        idle8();
        chk("t6_sat_hold", err4, 16'hFFFF);
        clr4 = 1'b1; sof4 = 4'h1;
        idle8();
        chk("t6_clr_wins", err4, 16'd0);
        clr4 = 1'b0; en4 = 1'b0; lv4 = 1'b0;
        idle8();
        chk("t6_dis_sel", {14'd0, sel4}, 16'd2);

        // Randomized traffic on dut8 against the model
        cand = cands[0];
        for (int r = 0; r < 3000; r++) begin
            int   x;
            bit   en, lv, clr;
            logic [7:0] s;
            if (r % 200 == 0) cand = cands[$urandom_range(0, 3)];
            en  = ($urandom_range(0, 40) != 0);
            lv  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 99) == 0);
            x   = $urandom_range(0, 7);
            if (x < 5)       s = cand;
            else if (x == 5) s = 8'h00;
            else             s = 8'($urandom);
            cyc(en, lv, s, clr);
        end

        // Async reset while locked
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (4) cyc(1'b1, 1'b1, 8'h55, 1'b0);
        chk("t6_prelock", {15'd0, av8}, 16'd1);
        #3 resetn = 1'b0;
        #1;
        m_reset();
        chk("t6_rst_valid", {15'd0, av8}, 16'd0);
        chk("t6_rst_state", {14'd0, st8}, 16'd0);
        chk("t6_rst_sel",   {13'd0, sel8}, 16'd0);
        chk("t6_rst_err",   err8, 16'd0);
        #2 resetn = 1'b1;
        idle8();
        chk("t6_post_hunt", {14'd0, st8}, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
